// File: rtl/pipe_pkg.sv
// Shared types and constants for the 3-stage RV32I pipeline controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipe_pkg;

    // RV32I major opcodes accepted by the decoder
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // MRET encoding within SYSTEM/funct3=0
    localparam logic [6:0] F7_MRET  = 7'b0011000;
    localparam logic [4:0] RS2_MRET = 5'd2;

    typedef enum logic [1:0] {
        PC_SEQ  = 2'd0,
        PC_BR   = 2'd1,
        PC_TRAP = 2'd2,
        PC_EPC  = 2'd3
    } pc_sel_e;

    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'd0,
        CAUSE_ILLEGAL = 2'd1,
        CAUSE_ECALL   = 2'd2,
        CAUSE_IRQ     = 2'd3
    } cause_e;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_e;

endpackage

// File: rtl/pipe_ctrl_sys_dec.sv
// Classifies the DE instruction as illegal / ECALL / MRET.
// Latency: purely combinational.
// Backpressure: none.
// Ports: opcode, funct3, funct7, rs2 in; illegal, ecall, mret out (one-hot or all 0).
module sys_dec
    import pipe_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic [4:0] rs2,
    output logic       illegal,
    output logic       ecall,
    output logic       mret
);

    always_comb begin
        illegal = 1'b0;
        ecall   = 1'b0;
        mret    = 1'b0;
        case (opcode)
            OP_REG, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH,
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: begin
                illegal = 1'b0;
            end
            OP_SYSTEM: begin
                // funct3 != 0 is a CSR access: legal, no control action
                if (funct3 == 3'b000) begin
                    if (funct7 == 7'd0 && rs2 == 5'd0) begin
                        ecall = 1'b1;
                    end else if (funct7 == F7_MRET && rs2 == RS2_MRET) begin
                        mret = 1'b1;
                    end else begin
                        illegal = 1'b1;
                    end
                end
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: stall/flush/kill, PC select, forwarding, trap/MRET, EPC/cause state.
// Latency: control outputs combinational; epc/mcause/mie/stall_cnt update on the next edge.
// Backpressure: dmem_req_mw without dmem_ack stalls the whole pipe until the ack cycle.
// Ports: DE fields (valid_de, opcode/funct3/funct7, rs1/rs2, pc_de, br_taken_de), MW status
//        (rd_mw, wr_en_mw, dmem_req_mw, dmem_ack), irq in; stall, flush_de, kill_de, pc_sel,
//        fwd_a/fwd_b, epc, mcause, mie, stall_cnt out.
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter logic [31:0] TRAP_VEC = 32'h0000_0100,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_de,
    input  logic [6:0]       opcode_de,
    input  logic [2:0]       funct3_de,
    input  logic [6:0]       funct7_de,
    input  logic [4:0]       rs1_de,
    input  logic [4:0]       rs2_de,
    input  logic [31:0]      pc_de,
    input  logic             br_taken_de,
    input  logic [4:0]       rd_mw,
    input  logic             wr_en_mw,
    input  logic             dmem_req_mw,
    input  logic             dmem_ack,
    input  logic             irq,
    output logic             stall,
    output logic             flush_de,
    output logic             kill_de,
    output logic [1:0]       pc_sel,
    output logic             fwd_a,
    output logic             fwd_b,
    output logic [31:0]      epc,
    output logic [1:0]       mcause,
    output logic             mie,
    output logic [CNT_W-1:0] stall_cnt
);

    // The trap address itself is applied by the fetch mux; this block only selects it.
    logic unused_trap_vec;
    assign unused_trap_vec = ^TRAP_VEC;

    state_e  state_q, state_d;
    logic    dec_illegal, dec_ecall, dec_mret;
    logic    take_trap, take_mret;
    cause_e  cause;
    pc_sel_e pc_src;

    sys_dec u_sys_dec (
        .opcode  (opcode_de),
        .funct3  (funct3_de),
        .funct7  (funct7_de),
        .rs2     (rs2_de),
        .illegal (dec_illegal),
        .ecall   (dec_ecall),
        .mret    (dec_mret)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= RUN;
        else        state_q <= state_d;
    end

    // Next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:      if (dmem_req_mw && !dmem_ack) state_d = MEM_WAIT;
            MEM_WAIT: if (dmem_ack)                 state_d = RUN;
            default:  state_d = RUN;
        endcase
    end

    // Outputs: stall takes effect in the same cycle the memory miss is seen.
    // DE events are only evaluated when the pipe is moving.
    always_comb begin
        stall     = (state_q == MEM_WAIT) ? !dmem_ack : (dmem_req_mw && !dmem_ack);
        take_trap = 1'b0;
        take_mret = 1'b0;
        cause     = CAUSE_NONE;
        pc_src    = PC_SEQ;
        flush_de  = 1'b0;
        kill_de   = 1'b0;
        if (!stall && valid_de) begin
            if (dec_illegal)      cause = CAUSE_ILLEGAL;
            else if (dec_ecall)   cause = CAUSE_ECALL;
            else if (irq && mie)  cause = CAUSE_IRQ;
            take_trap = (cause != CAUSE_NONE);
            if (take_trap) begin
                pc_src   = PC_TRAP;
                flush_de = 1'b1;
                kill_de  = 1'b1;   // trapping instruction must not retire
            end else if (dec_mret) begin
                take_mret = 1'b1;
                pc_src    = PC_EPC;
                flush_de  = 1'b1;
            end else if (br_taken_de) begin
                pc_src   = PC_BR;
                flush_de = 1'b1;
            end
        end
    end

    assign pc_sel = pc_src;

    // Forwarding ignores stall: the DE operands must be correct whenever they are sampled.
    assign fwd_a = wr_en_mw && (rd_mw != 5'd0) && (rd_mw == rs1_de);
    assign fwd_b = wr_en_mw && (rd_mw != 5'd0) && (rd_mw == rs2_de);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            epc       <= 32'd0;
            mcause    <= 2'd0;
            mie       <= 1'b1;
            stall_cnt <= '0;
        end else if (stall) begin
            if (stall_cnt != {CNT_W{1'b1}}) stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end else if (take_trap) begin
            epc    <= pc_de;     // a taken branch in DE re-executes after MRET
            mcause <= cause;
            mie    <= 1'b0;      // blocks re-entry while irq stays high
        end else if (take_mret) begin
            mie <= 1'b1;
        end
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Central pipeline controller for the 3-stage RV32I core (IF → DE → MW). It consumes the decoded fields of the instruction in DE and status from MW. It generates:
- stall, flush and kill controls;
- PC source selection;
- register-file forwarding selects;
- a minimal trap mechanism for illegal instruction, ECALL, MRET and external interrupt.

It owns the EPC and cause state.

## Interface
Parameters:
- TRAP_VEC, 32'h0000_0100, PC loaded on trap entry
- CNT_W, 16, width of stall-cycle counter

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- valid_de  in  1  DE holds a real instruction (0 = bubble)
- opcode_de  in  7  decoded opcode
- funct3_de  in  3  decoded funct3
- funct7_de  in  7  decoded funct7
- rs1_de, rs2_de  in  5 each  source registers
- pc_de  in  32  PC of DE instruction
- br_taken_de  in  1  branch/jump resolved taken in DE
- rd_mw  in  5  destination register in MW
- wr_en_mw  in  1  MW instruction writes register file
- dmem_req_mw  in  1  MW instruction accesses data memory
- dmem_ack  in  1  data memory completes access this cycle
- irq  in  1  level-sensitive external interrupt
- stall  out  1  hold PC, IF/DE and DE/MW registers
- flush_de  out  1  load bubble into IF/DE on next edge
- kill_de  out  1  load bubble into DE/MW on next edge
- pc_sel  out  2  0 PC+4, 1 branch target, 2 TRAP_VEC, 3 epc
- fwd_a, fwd_b  out  1 each  select MW writeback data for rs1/rs2
- epc  out  32  saved PC of trapping instruction
- mcause  out  2  0 none, 1 illegal, 2 ecall, 3 interrupt
- mie  out  1  interrupt enable
- stall_cnt  out  CNT_W  count of memory-stall cycles

## Operation
- FSM states are RUN and MEM_WAIT. Reset state is RUN.
- **RUN:**
  - If dmem_req_mw=1 and dmem_ack=0, go to MEM_WAIT with stall=1 in the same cycle (combinational).
  - Otherwise, evaluate events on the DE instruction in this priority: trap > mret > branch.
- **MEM_WAIT:**
  - stall=1 every cycle until dmem_ack=1.
  - In the ack cycle, stall=0 and state returns to RUN. DE events are evaluated normally in that cycle.
- While stall=1:
  - flush_de, kill_de, pc_sel are all 0;
  - no state other than stall_cnt changes;
  - irq is ignored.
- Instruction legality (only when valid_de=1):
  - Legal opcodes: 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111, 1110011.
  - SYSTEM (1110011) with funct3=0:
    - funct7=0 and rs2=0 is ECALL;
    - funct7=0011000 and rs2=00010 is MRET;
    - anything else is illegal.
  - SYSTEM with funct3≠0 is legal (CSR, no control action).
- **Trap:** condition is valid_de and (illegal | ecall | (irq & mie)).
  - pc_sel=2, flush_de=1, kill_de=1.
  - Registered on the edge: epc←pc_de, mie←0, mcause←cause.
  - Cause priority: illegal > ecall > interrupt.
- **MRET:** pc_sel=3, flush_de=1, kill_de=0, mie←1.
- **Branch:** when br_taken_de and valid_de, pc_sel=1, flush_de=1, kill_de=0.
- **Forwarding:**
  - fwd_a = wr_en_mw & (rd_mw≠0) & (rd_mw==rs1_de). fwd_b is the same using rs2_de.
  - Purely combinational, independent of stall.
- stall_cnt increments by 1 each cycle stall=1. It saturates at all-ones.

## Timing
- Reset values: state RUN, epc 0, mcause 0, mie 1, stall_cnt 0. All combinational outputs are 0 when inputs are idle.
- Control outputs are combinational from inputs and state; the datapath samples them on the next edge.
- Branch or trap penalty is exactly 1 bubble: the IF instruction is flushed, and the target instruction reaches DE 2 cycles after the event cycle.
- A trap taken with irq still high does not retrigger, because mie=0 from the next cycle.
- Trap and MRET cannot coexist. Trap with br_taken_de=1: trap wins and epc=pc_de, so the branch re-executes on return.
- valid_de=0 suppresses trap, mret and branch actions. irq waits for a valid DE instruction.
- Reset asserted mid-MEM_WAIT returns to RUN asynchronously; stall deasserts immediately.

## Structure
- Package pipe_pkg holds:
  - opcode localparams;
  - pc_sel enum (PC_SEQ, PC_BR, PC_TRAP, PC_EPC);
  - cause enum;
  - state enum (RUN, MEM_WAIT).
- One sub-module, sys_dec: combinational legality/ECALL/MRET classifier from opcode/funct3/funct7/rs2. Everything else is flat in pipe_ctrl.

## Test plan
- Reset, then idle inputs → stall=0, pc_sel=0, mie=1, epc=0, stall_cnt=0.
- dmem_req_mw=1 with dmem_ack low 3 cycles, then high → stall=1 for 3 cycles and 0 in the ack cycle; stall_cnt=3; no flush during stall.
- Valid BEQ with br_taken_de=1 → pc_sel=1, flush_de=1, kill_de=0 for one cycle.
- opcode 0000000 at pc_de=0x40 → pc_sel=2, flush_de=kill_de=1; next cycle epc=0x40, mcause=1, mie=0. Then MRET (funct7=0011000, rs2=2) → pc_sel=3 and mie=1.
- irq=1 held with valid ADD at pc_de=0x80 → single trap, mcause=3, epc=0x80. No second trap while irq stays high. irq during MEM_WAIT is not taken until stall drops.
- rd_mw=5, wr_en_mw=1, rs1_de=rs2_de=5 → fwd_a=fwd_b=1. Same with rd_mw=0 → both 0.
